// File: rtl/serial_link_minimum_axi_pkg.sv
// Shared constants and types for the minimum-width AXI serial link.
// Response flits carry a 1-bit channel tag in bit 0, payload above it.
package serial_link_minimum_axi_pkg;

   localparam int unsigned B_CH_SIZE = 4;
   localparam int unsigned R_CH_SIZE = 37;
   localparam int unsigned PhitWidth = 8;

   function automatic int unsigned ceil_div(
      input int unsigned a,
      input int unsigned b
   );
      return (a + b - 1) / b;
   endfunction

   localparam int unsigned RespFlitWidth =
      1 + ((B_CH_SIZE > R_CH_SIZE) ? B_CH_SIZE : R_CH_SIZE);
   localparam int unsigned NumPhitsB = ceil_div(1 + B_CH_SIZE, PhitWidth);
   localparam int unsigned NumPhitsR = ceil_div(1 + R_CH_SIZE, PhitWidth);

   localparam logic RespTypeB = 1'b0;
   localparam logic RespTypeR = 1'b1;

   typedef enum logic {
      SerIdle,
      SerSend
   } ser_state_e;

   typedef enum logic {
      SrcB,
      SrcR
   } resp_src_e;

endpackage

// File: rtl/serial_link_min_phit_serializer.sv
// Shifts a loaded flit out LSB-first as fixed-width phits.
// load_ok_o marks cycles where a new flit may be loaded without a bubble.
module serial_link_min_phit_serializer
   import serial_link_minimum_axi_pkg::*;
#(
   parameter int unsigned PhitW = 8,
   parameter int unsigned FlitW = 38,
   parameter int unsigned MaxPhits = 5,
   localparam int unsigned CntW = $clog2(MaxPhits + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [FlitW-1:0] flit_i,
   input  logic [CntW-1:0]  num_phits_i,
   output logic             load_ok_o,
   output logic [PhitW-1:0] phit_o,
   output logic             phit_valid_o,
   input  logic             phit_ready_i,
   output logic             phit_last_o
);

   localparam int unsigned ShW = MaxPhits * PhitW;

   ser_state_e       state_q;
   logic [ShW-1:0]   shift_q;
   logic [CntW-1:0]  cnt_q;
   logic [CntW-1:0]  num_q;
   logic             last_q;

   assign phit_o       = shift_q[PhitW-1:0];
   assign phit_valid_o = (state_q == SerSend);
   assign phit_last_o  = last_q;
   assign load_ok_o    = (state_q == SerIdle)
                       || (state_q == SerSend && last_q && phit_ready_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= SerIdle;
         shift_q <= '0;
         cnt_q   <= '0;
         num_q   <= '0;
         last_q  <= 1'b0;
      end else if (load_i && load_ok_o) begin
         state_q <= SerSend;
         shift_q <= ShW'(flit_i);
         cnt_q   <= '0;
         num_q   <= num_phits_i;
         last_q  <= (num_phits_i == CntW'(1));
      end else begin
         unique case (state_q)
            SerIdle: ;
            SerSend: begin
               if (phit_ready_i) begin
                  if (last_q) begin
                     state_q <= SerIdle;
                     shift_q <= '0;
                     cnt_q   <= '0;
                     last_q  <= 1'b0;
                  end else begin
                     shift_q <= shift_q >> PhitW;
                     cnt_q   <= cnt_q + CntW'(1);
                     // next phit is last when cnt+1 == num-1
                     last_q  <= ((cnt_q + CntW'(2)) == num_q);
                  end
               end
            end
            default: state_q <= SerIdle;
         endcase
      end
   end

endmodule

// File: rtl/serial_link_min_axi_resp_tx.sv
// Responder-side B/R transmitter: round-robin arbitration, channel tagging,
// and hand-off of the tagged flit to the phit serializer.
module serial_link_min_axi_resp_tx #(
   parameter int unsigned PhitWidth = serial_link_minimum_axi_pkg::PhitWidth,
   parameter int unsigned BChSize   = serial_link_minimum_axi_pkg::B_CH_SIZE,
   parameter int unsigned RChSize   = serial_link_minimum_axi_pkg::R_CH_SIZE
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [BChSize-1:0]   b_i,
   input  logic                 b_valid_i,
   output logic                 b_ready_o,
   input  logic [RChSize-1:0]   r_i,
   input  logic                 r_valid_i,
   output logic                 r_ready_o,
   output logic [PhitWidth-1:0] phit_o,
   output logic                 phit_valid_o,
   input  logic                 phit_ready_i,
   output logic                 phit_last_o
);

   import serial_link_minimum_axi_pkg::*;

   localparam int unsigned MaxCh = (BChSize > RChSize) ? BChSize : RChSize;
   localparam int unsigned FlitW = 1 + MaxCh;
   localparam int unsigned NB = ceil_div(1 + BChSize, PhitWidth);
   localparam int unsigned NR = ceil_div(1 + RChSize, PhitWidth);
   localparam int unsigned MaxPhits = (NB > NR) ? NB : NR;
   localparam int unsigned CntW = $clog2(MaxPhits + 1);

   resp_src_e        ptr_q;
   logic             load_ok;
   logic             grant_b;
   logic             grant_r;
   logic             want_b;
   logic             want_r;
   logic [FlitW-1:0] flit;
   logic [CntW-1:0]  num_phits;

   // Contested requests go to the pointer; a lone request always wins.
   assign want_b = b_valid_i && (!r_valid_i || ptr_q == SrcB);
   assign want_r = r_valid_i && (!b_valid_i || ptr_q == SrcR);

   always_comb begin
      grant_b = 1'b0;
      grant_r = 1'b0;
      if (load_ok && !rst_i) begin
         unique case (1'b1)
            want_b:  grant_b = 1'b1;
            want_r:  grant_r = 1'b1;
            default: ;
         endcase
      end
   end

   assign b_ready_o = grant_b;
   assign r_ready_o = grant_r;

   always_comb begin
      flit = '0;
      if (grant_r) begin
         flit[RChSize:1] = r_i;
         flit[0]         = RespTypeR;
         num_phits       = CntW'(NR);
      end else begin
         flit[BChSize:1] = b_i;
         flit[0]         = RespTypeB;
         num_phits       = CntW'(NB);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= SrcB;
      end else if (grant_b) begin
         ptr_q <= SrcR;
      end else if (grant_r) begin
         ptr_q <= SrcB;
      end
   end

   serial_link_min_phit_serializer #(
      .PhitW    (PhitWidth),
      .FlitW    (FlitW),
      .MaxPhits (MaxPhits)
   ) u_ser (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .load_i       (grant_b || grant_r),
      .flit_i       (flit),
      .num_phits_i  (num_phits),
      .load_ok_o    (load_ok),
      .phit_o       (phit_o),
      .phit_valid_o (phit_valid_o),
      .phit_ready_i (phit_ready_i),
      .phit_last_o  (phit_last_o)
   );

endmodule

// File: tb/tb_serial_link_min_axi_resp_tx.sv
// Scoreboard bench for the B/R response transmitter: directed cases
// followed by randomized traffic and link back-pressure.
module tb_serial_link_min_axi_resp_tx;

   localparam int PW = 8;
   localparam int BW = 4;
   localparam int RW = 37;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [BW-1:0] b_i = '0;
   logic          b_valid_i = 1'b0;
   logic          b_ready_o;
   logic [RW-1:0] r_i = '0;
   logic          r_valid_i = 1'b0;
   logic          r_ready_o;
   logic [PW-1:0] phit_o;
   logic          phit_valid_o;
   logic          phit_ready_i = 1'b1;
   logic          phit_last_o;

   serial_link_min_axi_resp_tx dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .b_i          (b_i),
      .b_valid_i    (b_valid_i),
      .b_ready_o    (b_ready_o),
      .r_i          (r_i),
      .r_valid_i    (r_valid_i),
      .r_ready_o    (r_ready_o),
      .phit_o       (phit_o),
      .phit_valid_o (phit_valid_o),
      .phit_ready_i (phit_ready_i),
      .phit_last_o  (phit_last_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int failures = 0;

   logic [8:0] sb[$];
   int         mptr = 0;
   bit         exp_v = 0;
   bit         hold_v = 0;
   logic [8:0] hold_val = '0;

   bit chk_reset = 0, chk_idle = 0, chk_busy = 0;
   bit chk_cf = 0, chk_end = 0, tmo = 0;

   task automatic chk(input bit ok, input string name,
                      input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic push_flit(input logic [63:0] pay, input int w,
                            input bit typ);
      logic [63:0] f;
      int n;
      f = (pay << 1) | 64'(typ);
      n = (w + 1 + PW - 1) / PW;
      for (int k = 0; k < n; k++) begin
         sb.push_back({k == n - 1, 8'(f >> (PW * k))});
      end
   endtask

   always @(negedge clk_i) begin
      if (rst_i) begin
         sb.delete();
         mptr = 0;
         exp_v = 0;
         hold_v = 0;
      end else begin
         if (tmo) begin
            checks++;
            failures++;
            $display("FAIL timeout waiting for grant t=%0t", $time);
         end
         if (chk_reset) begin
            chk(!phit_valid_o, "rst_valid", 64'(phit_valid_o), 0);
            chk(phit_o == 0, "rst_phit", 64'(phit_o), 0);
            chk(!phit_last_o, "rst_last", 64'(phit_last_o), 0);
            chk(!b_ready_o, "rst_b_ready", 64'(b_ready_o), 0);
            chk(!r_ready_o, "rst_r_ready", 64'(r_ready_o), 0);
         end
         if (chk_idle)
            chk(!phit_valid_o, "idle_after_rst", 64'(phit_valid_o), 0);
         if (chk_busy)
            chk(phit_valid_o, "no_bubble", 64'(phit_valid_o), 1);
         if (chk_cf)
            chk(phit_valid_o && phit_o == 8'hCF, "stall_hold",
                64'({phit_valid_o, phit_o}), 64'h1CF);
         if (chk_end)
            chk(sb.size() == 0, "drain_empty", 64'(sb.size()), 0);
         if (hold_v)
            chk(phit_valid_o && {phit_last_o, phit_o} == hold_val,
                "stable", 64'({phit_valid_o, phit_last_o, phit_o}),
                64'({1'b1, hold_val}));
         if (exp_v)
            chk(phit_valid_o, "first_phit_latency", 64'(phit_valid_o), 1);
         chk(!(b_ready_o && r_ready_o), "one_ready",
             64'({b_ready_o, r_ready_o}), 0);
         if (phit_valid_o && phit_ready_i) begin
            chk(sb.size() != 0, "unexpected_phit", 64'(phit_o), 0);
            if (sb.size() != 0) begin
               logic [8:0] e;
               e = sb.pop_front();
               chk({phit_last_o, phit_o} == e, "phit",
                   64'({phit_last_o, phit_o}), 64'(e));
            end
         end
         if (b_valid_i && b_ready_o || r_valid_i && r_ready_o) begin
            if (b_valid_i && r_valid_i)
               chk((r_ready_o ? 1 : 0) == mptr, "rr_order",
                   64'(r_ready_o), 64'(mptr));
            mptr = b_ready_o ? 1 : 0;
            if (b_ready_o) push_flit(64'(b_i), BW, 1'b0);
            else           push_flit(64'(r_i), RW, 1'b1);
         end
         exp_v = (b_valid_i && b_ready_o) || (r_valid_i && r_ready_o);
         hold_v = phit_valid_o && !phit_ready_i;
         hold_val = {phit_last_o, phit_o};
      end
   end

   bit hb, hr;

   task automatic step();
      @(negedge clk_i);
      hb = b_valid_i && b_ready_o;
      hr = r_valid_i && r_ready_o;
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_acc(input bit want_b);
      int n = 0;
      do begin
         step();
         n++;
      end while (!(want_b ? hb : hr) && n < 50);
      if (!(want_b ? hb : hr)) begin
         tmo = 1;
         step();
         tmo = 0;
      end
   endtask

   initial begin
      int cnt;
      repeat (3) step();
      rst_i = 0;
      chk_reset = 1;
      step();
      chk_reset = 0;

      // single B beat
      b_i = 4'b1011;
      b_valid_i = 1;
      wait_acc(1);
      b_valid_i = 0;
      repeat (3) step();

      // single R beat
      r_i = 37'h1_2345_6789;
      r_valid_i = 1;
      wait_acc(0);
      r_valid_i = 0;
      repeat (7) step();

      // both valid: alternation with no bubbles
      b_i = 4'h5;
      r_i = 37'h0_DEAD_BEEF;
      b_valid_i = 1;
      r_valid_i = 1;
      wait_acc(1);
      chk_busy = 1;
      cnt = 1;
      for (int i = 0; i < 40 && cnt < 4; i++) begin
         step();
         if (hb || hr) cnt++;
      end
      b_valid_i = 0;
      r_valid_i = 0;
      repeat (5) step();
      chk_busy = 0;
      repeat (3) step();

      // back-pressure on the second R phit
      r_i = 37'h1_2345_6789;
      r_valid_i = 1;
      wait_acc(0);
      r_valid_i = 0;
      step();
      phit_ready_i = 0;
      chk_cf = 1;
      repeat (3) step();
      chk_cf = 0;
      phit_ready_i = 1;
      repeat (6) step();

      // reset while the third R phit is pending
      r_valid_i = 1;
      wait_acc(0);
      r_valid_i = 0;
      repeat (2) step();
      rst_i = 1;
      step();
      rst_i = 0;
      chk_idle = 1;
      repeat (3) step();
      chk_idle = 0;
      b_i = 4'b1011;
      r_i = 37'h0_0000_0042;
      b_valid_i = 1;
      r_valid_i = 1;
      wait_acc(1);
      b_valid_i = 0;
      r_valid_i = 0;
      repeat (8) step();

      // four back-to-back B beats
      b_valid_i = 1;
      wait_acc(1);
      chk_busy = 1;
      cnt = 1;
      for (int i = 0; i < 20 && cnt < 4; i++) begin
         step();
         if (hb) begin
            cnt++;
            b_i = 4'($urandom);
         end
      end
      b_valid_i = 0;
      step();
      chk_busy = 0;
      repeat (3) step();

      // randomized traffic with link stalls
      for (int i = 0; i < 600; i++) begin
         step();
         if (hb) b_valid_i = 0;
         if (hr) r_valid_i = 0;
         if (!b_valid_i && $urandom_range(3) == 0) begin
            b_valid_i = 1;
            b_i = 4'($urandom);
         end
         if (!r_valid_i && $urandom_range(3) == 0) begin
            r_valid_i = 1;
            r_i = 37'({$urandom, $urandom});
         end
         phit_ready_i = ($urandom_range(3) != 0);
      end
      b_valid_i = 0;
      r_valid_i = 0;
      phit_ready_i = 1;
      repeat (20) step();
      chk_end = 1;
      step();
      chk_end = 0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
